gap_junction_sequencer: RTL and testbench
=========================================

// Module: gap_junction_sequencer
// PURPOSE
//  Drives the GapJunction HLS core's AXI-Stream input and drains its AXI-Stream output.
//  - Waits a power-up settle period, then on start streams NUM_FRAMES frames of FRAME_WORDS
//    words each into input_r.
//  - Consumes each result frame on output_r and checks frame length.
//  - Reports progress, completion and timeout/length errors to the PS-side status registers.
// PARAMETERS
//  STARTUP_CYCLES  20000  settle cycles after reset before start is honoured
//  FRAME_WORDS     16     input words per frame (2..65535)
//  NUM_FRAMES      8      frames per run (1..255)
//  TIMEOUT_CYCLES  4096   max cycles with no output beat while a result is pending
// PORTS
//  clk               in   1   core clock
//  reset_n           in   1   asynchronous, active-low reset
//  start             in   1   one-cycle pulse, begins a run
//  input_r_TDATA_0   out  32  stimulus word {frame_idx[15:0], word_idx[15:0]}
//  input_r_TVALID_0  out  1   stimulus valid
//  input_r_TLAST_0   out  1   high on word FRAME_WORDS-1 of each frame
//  input_r_TREADY_0  in   1   core accepts stimulus
//  output_r_TVALID_0 in   1   result valid
//  output_r_TLAST_0  in   1   result end-of-frame
//  output_r_TREADY_0 out  1   sequencer accepts result
//  busy              out  1   run in progress
//  done              out  1   sticky, all frames completed cleanly
//  timeout_err       out  1   sticky, output stalled TIMEOUT_CYCLES
//  len_err           out  1   sticky, result TLAST beat count != FRAME_WORDS
//  frame_count       out  8   frames fully completed this run
//  latency_max       out  16  see CONFIGURATION
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state S_INIT; startup counter 0.
//  - reset_n low mid-run aborts immediately: no further beats, TVALID/TREADY drop asynchronously.
//  FSM states
//  - S_INIT: count STARTUP_CYCLES, then go to S_IDLE. start is ignored in S_INIT.
//  - S_IDLE: on start, clear all sticky flags and counters, busy=1, go to S_XFER.
//  - S_XFER, send side:
//    - TVALID=1 until the word_idx of FRAME_WORDS-1 is accepted.
//    - TDATA/TLAST are held stable while TVALID && !TREADY.
//    - word_idx advances only on a TVALID&&TREADY beat.
//  - S_XFER, receive side:
//    - TREADY=1 throughout S_XFER; result beats are accepted while the send side is still sending.
//    - A result beat count is kept per frame.
//    - On a TLAST beat, count != FRAME_WORDS sets len_err; the frame is still closed.
//  - Frame close:
//    - A frame closes when both its send is finished and its result TLAST is received.
//    - On close, frame_count increments.
//    - If frame_count reaches NUM_FRAMES: go to S_DONE. Otherwise frame_idx increments, word_idx=0.
//  - Timeout counter
//    - Clears on every accepted result beat.
//    - Counts while the send of the current frame is finished and its result is pending.
//    - On reaching TIMEOUT_CYCLES: set timeout_err, go to S_ERR.
//  - S_DONE: done=1, busy=0, TVALID=TREADY=0.
//  - S_ERR: busy=0, TVALID=TREADY=0.
//  - From S_DONE or S_ERR, start goes to S_IDLE handling in the same cycle, i.e. a new run.
//  Boundary cases
//  - start while busy: ignored.
//  - Result beat arriving in the same cycle as the last stimulus beat: both counted.
//  - Result TVALID outside S_XFER: not accepted, since TREADY=0.
// CONFIGURATION
//  GJ_SEQ_LATENCY_EN
//  - Defined: a 16-bit counter runs from a frame's first stimulus beat to its result TLAST beat.
//    - latency_max holds the run maximum and saturates at 16'hFFFF.
//    - latency_max is cleared on start.
//  - Undefined: latency_max is tied to 16'd0 and no counter logic is built.
// STRUCTURE
//  Package gj_seq_pkg
//  - State enum: S_INIT, S_IDLE, S_XFER, S_DONE, S_ERR.
//  - Width constants: data 32, index 16, latency 16.
//  - Stimulus pattern function mk_word(frame_idx, word_idx).
//  Sub-module gj_seq_timer
//  - Loadable up-counter with terminal-count flag.
//  - Instantiated twice: startup settle and timeout.
// TESTING
//  1. Reset, start at cycle 100 -> ignored; TVALID stays 0 until cycle 20000+.
//  2. FRAME_WORDS=4, NUM_FRAMES=2, TREADY always 1, echo 4-beat result frames
//     -> 8 input beats, TDATA 0x00000000..0x00000003 then 0x00010000..0x00010003;
//        done=1, frame_count=2.
//  3. Toggle input TREADY every other cycle -> TDATA/TLAST held stable while stalled; no beat lost.
//  4. Return a 3-beat result frame for FRAME_WORDS=4 -> len_err=1, run still completes, done=1.
//  5. Withhold result after frame 0, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 cycles,
//     state S_ERR, frame_count=0.
//  6. reset_n low in mid-frame -> outputs 0 immediately; after release S_INIT replays settle.

Source files
------------

// File: rtl/gj_seq_pkg.sv
// Shared types, widths and the stimulus word pattern for the GapJunction stream sequencer.
package gj_seq_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 16;
  localparam int LAT_W  = 16;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] frame_idx;
    logic [IDX_W-1:0] word_idx;
  } stim_word_t;

  function automatic logic [DATA_W-1:0] mk_word(input logic [IDX_W-1:0] frame_idx,
                                                input logic [IDX_W-1:0] word_idx);
    stim_word_t w;
    w.frame_idx = frame_idx;
    w.word_idx  = word_idx;
    return w;
  endfunction

endpackage

// File: rtl/gj_seq_timer.sv
// Clearable up-counter that stops at a terminal value and flags it; no stall, result visible next cycle.
module gj_seq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == terminal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gap_junction_sequencer.sv
// Streams NUM_FRAMES stimulus frames into the GapJunction core and drains/checks its results; stimulus waits on TREADY, results always accepted in S_XFER.
// Optional GJ_SEQ_LATENCY_EN builds the first-beat-to-result-TLAST latency tracker behind latency_max.
module gap_junction_sequencer
  import gj_seq_pkg::*;
#(
  parameter int STARTUP_CYCLES = 20000,
  parameter int FRAME_WORDS    = 16,
  parameter int NUM_FRAMES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [DATA_W-1:0] input_r_TDATA_0,
  output logic              input_r_TVALID_0,
  output logic              input_r_TLAST_0,
  input  logic              input_r_TREADY_0,
  input  logic              output_r_TVALID_0,
  input  logic              output_r_TLAST_0,
  output logic              output_r_TREADY_0,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              len_err,
  output logic [7:0]        frame_count,
  output logic [LAT_W-1:0]  latency_max
);

  localparam int ST_W = $clog2(STARTUP_CYCLES + 2);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [ST_W-1:0]  ST_TERM   = ST_W'(STARTUP_CYCLES);
  localparam logic [TO_W-1:0]  TO_TERM   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W:0]   RX_LEN    = (IDX_W + 1)'(FRAME_WORDS);
  localparam logic [7:0]       LAST_FRM  = 8'(NUM_FRAMES - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0] frame_idx;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W:0]   rx_cnt;
  logic [7:0]       frame_cnt;
  logic             send_done;
  logic             rx_done;
  logic             timeout_q;
  logic             len_err_q;

  logic in_xfer, tx_vld, tx_beat, last_word;
  logic rx_beat, rx_last_beat, send_fin, rx_fin;
  logic frame_close, final_frame, pending, timed_out, run_start;
  logic st_tc, to_tc;

  assign in_xfer      = (state == S_XFER);
  assign tx_vld       = in_xfer && !send_done;
  assign tx_beat      = tx_vld && input_r_TREADY_0;
  assign last_word    = (word_idx == LAST_WORD);
  assign rx_beat      = in_xfer && output_r_TVALID_0;
  assign rx_last_beat = rx_beat && output_r_TLAST_0;
  assign send_fin     = send_done || (tx_beat && last_word);
  assign rx_fin       = rx_done || rx_last_beat;
  assign frame_close  = in_xfer && send_fin && rx_fin;
  assign final_frame  = (frame_cnt == LAST_FRM);
  // Result owed for a fully sent frame: the only window in which a stall is an error.
  assign pending      = in_xfer && send_done && !rx_done;
  assign timed_out    = pending && to_tc && !rx_beat;
  assign run_start    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  gj_seq_timer #(.WIDTH(ST_W)) u_settle (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (1'b0),
    .en       (state == S_INIT),
    .terminal (ST_TERM),
    .tc       (st_tc)
  );

  gj_seq_timer #(.WIDTH(TO_W)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (!pending || rx_beat || run_start),
    .en       (pending),
    .terminal (TO_TERM),
    .tc       (to_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT: if (st_tc) state_nxt = S_IDLE;
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_XFER;
      S_XFER: begin
        if (frame_close && final_frame) begin
          state_nxt = S_DONE;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_idx <= '0;
      word_idx  <= '0;
      rx_cnt    <= '0;
      frame_cnt <= '0;
      send_done <= 1'b0;
      rx_done   <= 1'b0;
      timeout_q <= 1'b0;
      len_err_q <= 1'b0;
    end else if (run_start) begin
      frame_idx <= '0;
      word_idx  <= '0;
      rx_cnt    <= '0;
      frame_cnt <= '0;
      send_done <= 1'b0;
      rx_done   <= 1'b0;
      timeout_q <= 1'b0;
      len_err_q <= 1'b0;
    end else if (in_xfer) begin
      if (tx_beat) begin
        if (last_word) begin
          word_idx  <= '0;
          send_done <= 1'b1;
        end else begin
          word_idx <= word_idx + IDX_W'(1);
        end
      end
      if (rx_beat) begin
        if (output_r_TLAST_0) begin
          rx_cnt  <= '0;
          rx_done <= 1'b1;
          if ((rx_cnt + (IDX_W + 1)'(1)) != RX_LEN) len_err_q <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + (IDX_W + 1)'(1);
        end
      end
      // Closing a frame re-arms both halves; it must win over the flags set above.
      if (frame_close) begin
        frame_cnt <= frame_cnt + 8'd1;
        send_done <= 1'b0;
        rx_done   <= 1'b0;
        if (!final_frame) frame_idx <= frame_idx + IDX_W'(1);
      end
      if (timed_out) timeout_q <= 1'b1;
    end
  end

`ifdef GJ_SEQ_LATENCY_EN
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_max;
  logic             lat_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
      lat_max <= '0;
      lat_run <= 1'b0;
    end else if (run_start) begin
      lat_cnt <= '0;
      lat_max <= '0;
      lat_run <= 1'b0;
    end else if (in_xfer) begin
      if (lat_run && (lat_cnt != '1)) lat_cnt <= lat_cnt + LAT_W'(1);
      if (tx_beat && (word_idx == '0)) begin
        lat_run <= 1'b1;
        lat_cnt <= '0;
      end
      if (rx_last_beat && lat_run) begin
        lat_run <= 1'b0;
        if (lat_cnt > lat_max) lat_max <= lat_cnt;
      end
    end else begin
      lat_run <= 1'b0;
    end
  end

  assign latency_max = lat_max;
`else
  assign latency_max = '0;
`endif

  assign input_r_TDATA_0   = mk_word(frame_idx, word_idx);
  assign input_r_TVALID_0  = tx_vld;
  assign input_r_TLAST_0   = tx_vld && last_word;
  assign output_r_TREADY_0 = in_xfer;
  assign busy              = in_xfer;
  assign done              = (state == S_DONE);
  assign timeout_err       = timeout_q;
  assign len_err           = len_err_q;
  assign frame_count       = frame_cnt;

endmodule

// File: tb/tb_gap_junction_sequencer.sv
// Table-driven runs against a scoreboard of stream beats, plus settle, timeout and mid-run reset sequences.
module tb_gap_junction_sequencer;

  localparam int ST = 20000;
  localparam int FW = 4;
  localparam int NF = 2;
  localparam int TO = 64;

  localparam int M_ECHO  = 0;
  localparam int M_SHORT = 1;
  localparam int M_LOCK  = 2;
  localparam int M_HOLD  = 3;

  typedef struct {
    int mode;
    int rdy_mode;
    int exp_done;
    int exp_len;
    int exp_to;
    int exp_fc;
    int exp_words;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        in_rdy;
  logic        out_vld;
  logic        out_last;
  logic        out_rdy;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        len_err;
  logic [7:0]  frame_count;
  logic [15:0] latency_max;

  int checks;
  int failures;

  gap_junction_sequencer #(
    .STARTUP_CYCLES (ST),
    .FRAME_WORDS    (FW),
    .NUM_FRAMES     (NF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .input_r_TDATA_0   (tdata),
    .input_r_TVALID_0  (tvalid),
    .input_r_TLAST_0   (tlast),
    .input_r_TREADY_0  (in_rdy),
    .output_r_TVALID_0 (out_vld),
    .output_r_TLAST_0  (out_last),
    .output_r_TREADY_0 (out_rdy),
    .busy              (busy),
    .done              (done),
    .timeout_err       (timeout_err),
    .len_err           (len_err),
    .frame_count       (frame_count),
    .latency_max       (latency_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Settle window: start pulses inside it must be ignored and nothing may stream.
  task automatic settle(input int early_start);
    bit quiet_bad;
    quiet_bad = 1'b0;
    for (int i = 0; i < ST + 10; i++) begin
      @(negedge clk);
      start = (i == early_start) || (i == ST - 10);
      if (tvalid || busy || out_rdy) quiet_bad = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("settle_quiet", {31'd0, quiet_bad}, 32'd0);
    chk("settle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int  sent, tx_frames, rx_frames, rx_in_frame, idle, closed, w;
    bit  ended, stall_prev, rdy, ovld, olast, tx, pend;
    bit  q[$];
    logic [31:0] prev_dat, exp_dat;
    logic        prev_last;
    sent = 0; tx_frames = 0; rx_frames = 0; rx_in_frame = 0; idle = 0;
    ended = 1'b0; stall_prev = 1'b0; prev_dat = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; in_rdy = 1'b0; out_vld = 1'b0; out_last = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      start  = 1'b0;
      closed = (tx_frames < rx_frames) ? tx_frames : rx_frames;
      if (timeout_err) begin
        chk($sformatf("timeout_window idle=%0d", idle),
            (idle >= TO && idle <= TO + 1) ? 32'd1 : 32'd0, 32'd1);
        ended = 1'b1;
        break;
      end
      chk("frame_count", {24'd0, frame_count}, closed);
      chk("busy", {31'd0, busy}, (closed < NF) ? 32'd1 : 32'd0);
      chk("done", {31'd0, done}, (closed == NF) ? 32'd1 : 32'd0);
      chk("out_ready", {31'd0, out_rdy}, (closed < NF) ? 32'd1 : 32'd0);
      if (closed == NF) begin
        ended = 1'b1;
        break;
      end
      if (idle > TO + 2) begin
        chk("timeout_missing", 32'd0, 32'd1);
        ended = 1'b1;
        break;
      end
      if (stall_prev) begin
        chk("hold_vld", {31'd0, tvalid}, 32'd1);
        chk("hold_dat", tdata, prev_dat);
        chk("hold_last", {31'd0, tlast}, {31'd0, prev_last});
      end
      start = (it == 5);
      case (v.rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (it % 2 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      in_rdy = rdy;
      if (v.mode == M_LOCK) begin
        ovld  = tvalid && rdy;
        olast = tlast;
      end else begin
        ovld  = (q.size() > 0) && ($urandom_range(0, 3) != 0);
        olast = ovld ? q[0] : 1'b0;
      end
      out_vld  = ovld;
      out_last = olast;
      tx   = tvalid && rdy;
      pend = (tx_frames > rx_frames);
      if (tx) begin
        w = sent % FW;
        exp_dat = ((sent / FW) << 16) | w;
        chk("tx_data", tdata, exp_dat);
        chk("tx_last", {31'd0, tlast}, (w == FW - 1) ? 32'd1 : 32'd0);
        if (v.mode == M_ECHO) q.push_back(w == FW - 1);
        if (v.mode == M_SHORT && w != 0) q.push_back(w == FW - 1);
        if (w == FW - 1) tx_frames++;
        sent++;
      end
      if (ovld) begin
        if (v.mode != M_LOCK) void'(q.pop_front());
        rx_in_frame++;
        if (olast) begin
          rx_frames++;
          rx_in_frame = 0;
        end
      end
      idle = (pend && !ovld) ? idle + 1 : 0;
      stall_prev = tvalid && !rdy;
      prev_dat   = tdata;
      prev_last  = tlast;
    end
    if (!ended) chk("run_bound", 32'd0, 32'd1);
    start = 1'b0; in_rdy = 1'b0; out_vld = 1'b0; out_last = 1'b0;
    chk("end_done", {31'd0, done}, v.exp_done);
    chk("end_len_err", {31'd0, len_err}, v.exp_len);
    chk("end_timeout", {31'd0, timeout_err}, v.exp_to);
    chk("end_frames", {24'd0, frame_count}, v.exp_fc);
    chk("end_words", sent, v.exp_words);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_tvalid", {31'd0, tvalid}, 32'd0);
    chk("end_tready", {31'd0, out_rdy}, 32'd0);
`ifndef GJ_SEQ_LATENCY_EN
    chk("latency_tied", {16'd0, latency_max}, 32'd0);
`endif
  endtask

  // Result beats offered while not in a run must be refused and leave status alone.
  task automatic outside_noise(input int exp_fc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_vld = 1'b1; out_last = 1'b1;
      chk("noise_tready", {31'd0, out_rdy}, 32'd0);
    end
    @(negedge clk);
    out_vld = 1'b0; out_last = 1'b0;
    chk("noise_frames", {24'd0, frame_count}, exp_fc);
  endtask

  vec_t vecs[7];

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; in_rdy = 1'b0; out_vld = 1'b0; out_last = 1'b0;

    vecs[0] = '{M_ECHO,  0, 1, 0, 0, NF, NF * FW};
    vecs[1] = '{M_ECHO,  1, 1, 0, 0, NF, NF * FW};
    vecs[2] = '{M_LOCK,  0, 1, 0, 0, NF, NF * FW};
    vecs[3] = '{M_SHORT, 0, 1, 1, 0, NF, NF * FW};
    vecs[4] = '{M_ECHO,  2, 1, 0, 0, NF, NF * FW};
    vecs[5] = '{M_HOLD,  0, 0, 0, 1, 0,  FW};
    vecs[6] = '{M_ECHO,  2, 1, 0, 0, NF, NF * FW};

    repeat (3) @(negedge clk);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tready", {31'd0, out_rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    chk("rst_frames", {24'd0, frame_count}, 32'd0);
    chk("rst_latency", {16'd0, latency_max}, 32'd0);
    reset_n = 1'b1;

    settle(100);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      outside_noise(vecs[i].exp_fc);
    end
    for (int i = 0; i < 3; i++) begin
      run_vec(vecs[4]);
    end

    // Mid-frame reset: stream stops asynchronously, then settle is replayed.
    @(negedge clk);
    start = 1'b1; in_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_tvalid", {31'd0, tvalid}, 32'd1);
    chk("pre_reset_tdata", tdata, 32'h0000_0002);
    #2 reset_n = 1'b0;
    #1;
    chk("async_tvalid", {31'd0, tvalid}, 32'd0);
    chk("async_tready", {31'd0, out_rdy}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_tdata", tdata, 32'd0);
    chk("async_frames", {24'd0, frame_count}, 32'd0);
    in_rdy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    settle(50);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
